seven_seg_monitor: RTL
======================

# seven_seg_monitor

- Receive-side counterpart of the scanned display path: observes the multiplexed anode/segment bus driven by the scanner and decoder and reconstructs the four displayed hex digits.
- Used in the board loop-back and self-check harness, clocked by the 100 MHz board clock alongside the display driver.
- Synchronises the bus and waits for each anode dwell to settle.
- Decodes segment patterns back to nibbles, and flags illegal bus states and a stalled scan.

## Interface

Parameters:
- SETTLE_CYCLES, 4: consecutive unchanged synchronised samples required before a dwell is captured; legal range 1–255.
- STALL_CYCLES, 1_000_000: clocks without any anode change before `stalled` asserts; minimum 2.

Ports:
- clock  in  1  board clock.
- reset  in  1  asynchronous, active-low; clears all state.
- anode  in  4  observed anodes, active-low; bit i selects digit i.
- seg  in  7  observed segments, active-low; seg[0]=a … seg[6]=g.
- clear_err  in  1  synchronous pulse; clears the sticky error flags.
- digits  out  16  recovered digits; digit i is in digits[4i+3:4i].
- digit_valid  out  4  bit i set when the last capture of digit i decoded to a legal pattern.
- frame_done  out  1  one-cycle pulse when all four positions have been captured since the previous pulse.
- err_multi  out  1  sticky; a settled dwell had more than one anode low.
- err_pattern  out  1  sticky; a settled dwell carried an unrecognised segment pattern.
- stalled  out  1  level; anode has not changed for STALL_CYCLES clocks.

## Operation

- anode and seg pass through a 2-flop synchroniser, 11 bits wide.
- The synchronised pair is compared with its previous-cycle value; any difference zeroes the settle counter.
- FSM:
  - WAIT: pair changing or not yet stable. When the counter reaches SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE: one cycle. Evaluate the pair, then go to HOLD.
  - HOLD: hold until the pair changes, then go to WAIT. Exactly one capture per dwell.
- Capture rules, by anode pattern:
  - All anodes high (blank): no update, no error.
  - Exactly one anode low (index i): decode seg.
    - Legal pattern: write the nibble to digit i, set digit_valid[i], set seen[i].
    - Illegal pattern: leave digit i unchanged, clear digit_valid[i], set seen[i], set err_pattern.
  - Two or more anodes low: no digit update, set err_multi.
- Legal active-low patterns, seg[6:0] written g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Frame tracking:
  - When seen becomes 4'b1111, frame_done pulses and seen clears in the same cycle.
  - digits and digit_valid hold their values.
- Stall detection:
  - The stall counter increments every clock while the synchronised anode is unchanged.
  - It resets to 0 on an anode change, and stalled deasserts on the same edge.
  - stalled asserts when the count reaches STALL_CYCLES and saturates there.
- clear_err clears err_multi and err_pattern. If clear_err and a new error occur in the same cycle, the error wins and the flag stays set.

## Timing

- Reset values: digits=0, digit_valid=0, frame_done=0, err_multi=0, err_pattern=0, stalled=0. FSM is in WAIT; seen, the settle counter and the stall counter are 0.
- Latency: digits, digit_valid, err_* and frame_done update exactly SETTLE_CYCLES+3 rising edges after the first edge that samples the new pin values, provided the pins are held stable throughout.
- A dwell shorter than SETTLE_CYCLES+1 synchronised samples is ignored entirely.
- Reset asserted mid-dwell returns everything to reset values immediately. After release, a dwell still on the pins is captured as new.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package seven_seg_pkg holds:
  - the 16 segment-pattern constants, shared with the display decoder;
  - the FSM state encoding (WAIT, CAPTURE, HOLD);
  - the digit-index width.
- Sub-module seg_pattern_decode: combinational 7-bit pattern in, 4-bit nibble plus legal flag out.
- Counter widths are sized with $clog2 of the respective parameter.

## Test plan

- Scan digits 3,2,1,0 showing 1,2,3,4 at 10 clocks per dwell (SETTLE_CYCLES=4) -> digits=16'h1234, digit_valid=4'hF, one frame_done pulse per full scan.
- Dwell of 4 clocks on anode=4'b1110, seg=7'b0000000 -> no capture; digits are unchanged.
- anode=4'b1100 held for 10 clocks -> err_multi=1 and no digit change. Then pulse clear_err with no error present -> err_multi=0.
- anode=4'b1101, seg=7'b1111111 held -> err_pattern=1, digit_valid[1]=0, digit 1 unchanged.
- Hold anode=4'b0111 for STALL_CYCLES (set to 20) clocks -> stalled=1. Change the anode -> stalled=0 on that edge.
- Assert reset in the middle of a dwell that decodes to 8 -> all outputs return to 0 immediately. After release, digit 8 is captured SETTLE_CYCLES+3 edges later.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display path:
// active-low segment patterns, monitor FSM states and anode classification.
package seven_seg_pkg;

   localparam int NUM_DIGITS  = 4;
   localparam int DIGIT_IDX_W = $clog2(NUM_DIGITS);

   // Active-low segment patterns, bit order g..a.
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_CAPTURE,
      ST_HOLD
   } mon_state_e;

   typedef enum logic [1:0] {
      ANODE_BLANK,
      ANODE_SINGLE,
      ANODE_MULTI
   } anode_kind_e;

   typedef struct packed {
      anode_kind_e            kind;
      logic [DIGIT_IDX_W-1:0] idx;
   } anode_info_t;

   function automatic anode_info_t classify_anode(input logic [NUM_DIGITS-1:0] anode);
      anode_info_t info;
      info.kind = ANODE_MULTI;
      info.idx  = DIGIT_IDX_W'(0);
      case (anode)
         4'b1111: info.kind = ANODE_BLANK;
         4'b1110: begin info.kind = ANODE_SINGLE; info.idx = DIGIT_IDX_W'(0); end
         4'b1101: begin info.kind = ANODE_SINGLE; info.idx = DIGIT_IDX_W'(1); end
         4'b1011: begin info.kind = ANODE_SINGLE; info.idx = DIGIT_IDX_W'(2); end
         4'b0111: begin info.kind = ANODE_SINGLE; info.idx = DIGIT_IDX_W'(3); end
         default: info.kind = ANODE_MULTI;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-low seven-segment pattern back to its hex nibble;
// legal is low for any pattern outside the sixteen glyphs.
module seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       legal
);

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_monitor.sv
// Watches a multiplexed anode/segment bus, captures each settled dwell once,
// rebuilds the four displayed digits and flags bus errors and scan stalls.
module seven_seg_monitor
   import seven_seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int STALL_CYCLES  = 1_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  anode,
   input  logic [6:0]  seg,
   input  logic        clear_err,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        err_multi,
   output logic        err_pattern,
   output logic        stalled
);

   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int STALL_W  = $clog2(STALL_CYCLES + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [STALL_W-1:0]  STALL_MAX  = STALL_W'(STALL_CYCLES);

   logic [10:0]                sync1_q, sync2_q;
   mon_state_e                 state_q, state_d;
   logic [SETTLE_W-1:0]        settle_cnt_q, settle_cnt_d;
   logic [STALL_W-1:0]         stall_cnt_q, stall_cnt_d;
   logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]      valid_q, valid_d;
   logic [NUM_DIGITS-1:0]      seen_q, seen_d;
   logic                       frame_done_q, frame_done_d;
   logic                       err_multi_q, err_multi_d;
   logic                       err_pattern_q, err_pattern_d;
   logic                       stalled_q, stalled_d;

   logic        pair_changed, anode_changed;
   logic [3:0]  dec_nibble;
   logic        dec_legal;
   anode_info_t anode_info;

   seg_pattern_decode u_decode (
      .seg    (sync2_q[6:0]),
      .nibble (dec_nibble),
      .legal  (dec_legal)
   );

   // Change is seen one stage early (incoming vs. synchronised value) so the
   // settle count starts on the same edge the new value lands in sync2_q.
   assign pair_changed  = (sync1_q != sync2_q);
   assign anode_changed = (sync1_q[10:7] != sync2_q[10:7]);
   assign anode_info    = classify_anode(sync2_q[10:7]);

   always_comb begin
      settle_cnt_d  = pair_changed ? '0 :
                      (settle_cnt_q == SETTLE_MAX) ? settle_cnt_q : settle_cnt_q + 1'b1;
      stall_cnt_d   = anode_changed ? '0 :
                      (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
      stalled_d     = (stall_cnt_d == STALL_MAX);
      state_d       = state_q;
      digits_d      = digits_q;
      valid_d       = valid_q;
      seen_d        = seen_q;
      frame_done_d  = 1'b0;
      // A fresh error in the same cycle as clear_err re-sets the flag below.
      err_multi_d   = err_multi_q & ~clear_err;
      err_pattern_d = err_pattern_q & ~clear_err;

      case (state_q)
         ST_WAIT: begin
            if (settle_cnt_d == SETTLE_MAX) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = pair_changed ? ST_WAIT : ST_HOLD;
            case (anode_info.kind)
               ANODE_SINGLE: begin
                  seen_d[anode_info.idx] = 1'b1;
                  if (dec_legal) begin
                     digits_d[anode_info.idx] = dec_nibble;
                     valid_d[anode_info.idx]  = 1'b1;
                  end else begin
                     valid_d[anode_info.idx]  = 1'b0;
                     err_pattern_d            = 1'b1;
                  end
               end
               ANODE_MULTI: err_multi_d = 1'b1;
               default: ;
            endcase
         end
         ST_HOLD: begin
            if (pair_changed) state_d = ST_WAIT;
         end
         default: state_d = ST_WAIT;
      endcase

      if (seen_d == '1) begin
         frame_done_d = 1'b1;
         seen_d       = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q       <= '1;
         sync2_q       <= '1;
         state_q       <= ST_WAIT;
         settle_cnt_q  <= '0;
         stall_cnt_q   <= '0;
         digits_q      <= '0;
         valid_q       <= '0;
         seen_q        <= '0;
         frame_done_q  <= 1'b0;
         err_multi_q   <= 1'b0;
         err_pattern_q <= 1'b0;
         stalled_q     <= 1'b0;
      end else begin
         sync1_q       <= {anode, seg};
         sync2_q       <= sync1_q;
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         digits_q      <= digits_d;
         valid_q       <= valid_d;
         seen_q        <= seen_d;
         frame_done_q  <= frame_done_d;
         err_multi_q   <= err_multi_d;
         err_pattern_q <= err_pattern_d;
         stalled_q     <= stalled_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign frame_done  = frame_done_q;
   assign err_multi   = err_multi_q;
   assign err_pattern = err_pattern_q;
   assign stalled     = stalled_q;

endmodule
